muldiv_iter: RTL and testbench

//  Iterative, parametrised multiply/divide unit for the EX stage; successor to the fixed 32-bit ALU divider.

---
 rtl/muldiv_iter_pkg.sv | 34 +++
 rtl/muldiv_iter_if.sv | 38 +++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_iter.sv | 139 +++++++++++++
 tb/tb_muldiv_iter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_iter_pkg.sv
// Shared opcode values, FSM states and opcode decode helpers for the iterative multiply/divide unit.
// Optional build macro used by this block: MDU_DIV0_EN (zero-divisor fast path and div0 flag).
package muldiv_iter_pkg;

   localparam int OP_MULTU = 3;
   localparam int OP_DIVU  = 4;
   localparam int OP_MULT  = 13;
   localparam int OP_DIV   = 14;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic {
      M_MUL = 1'b0,
      M_DIV = 1'b1
   } mode_t;

   function automatic logic op_legal(input int op_code);
      return (op_code == OP_MULTU) || (op_code == OP_DIVU) ||
             (op_code == OP_MULT)  || (op_code == OP_DIV);
   endfunction

   function automatic logic op_is_div(input int op_code);
      return (op_code == OP_DIVU) || (op_code == OP_DIV);
   endfunction

   function automatic logic op_is_signed(input int op_code);
      return (op_code == OP_MULT) || (op_code == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_iter_if.sv
// Request/response bundle of the multiply/divide unit; the div0 flag exists only with MDU_DIV0_EN.
interface muldiv_iter_if #(
   parameter int WIDTH = 32,
   parameter int OP_W  = 4
);
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [OP_W-1:0]  op;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic             busy;
`ifdef MDU_DIV0_EN
   logic             div0;

   modport master (
      output flush, in_valid, op, x, y, out_ready,
      input  in_ready, out_valid, lo, hi, busy, div0
   );
   modport slave (
      input  flush, in_valid, op, x, y, out_ready,
      output in_ready, out_valid, lo, hi, busy, div0
   );
`else
   modport master (
      output flush, in_valid, op, x, y, out_ready,
      input  in_ready, out_valid, lo, hi, busy
   );
   modport slave (
      input  flush, in_valid, op, x, y, out_ready,
      output in_ready, out_valid, lo, hi, busy
   );
`endif
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: radix-2 shift-add (multiply) or restoring subtract (divide).
// Accumulator layout: upper half = partial product / partial remainder, lower half = multiplier / dividend+quotient.
module muldiv_step
   import muldiv_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_opnd,
   input  mode_t              i_mode,
   output logic [2*WIDTH-1:0] o_acc,
   output logic               o_qbit
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      o_acc   = '0;
      o_qbit  = 1'b0;
      w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, (i_acc[0] ? i_opnd : {WIDTH{1'b0}})};
      w_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
      w_diff  = w_shift - {1'b0, i_opnd};
      if (i_mode == M_MUL) begin
         o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end else begin
         // Non-negative trial difference means the divisor fits: keep it and emit a 1.
         o_qbit = ~w_diff[WIDTH];
         o_acc  = {(o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), i_acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply/divide unit with valid/ready on both sides and exception flush.
// MDU_DIV0_EN: zero divisor skips the iterations and raises div0 alongside the result.
module muldiv_iter
   import muldiv_iter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OP_W  = 4
) (
   input  logic          clk,
   input  logic          rst,
   muldiv_iter_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]     r_opnd;
   logic [WIDTH-1:0]     r_lo;
   logic [WIDTH-1:0]     r_hi;
   mode_t                r_mode;
   logic                 r_neg_q;
   logic                 r_neg_r;
   logic                 r_div0;

   logic                 w_accept;
   logic                 w_op_div;
   logic                 w_op_signed;
   logic                 w_sx;
   logic                 w_sy;
   logic [WIDTH-1:0]     w_x_mag;
   logic [WIDTH-1:0]     w_y_mag;
   logic [2*WIDTH-1:0]   w_step_acc;
   logic                 w_step_qbit;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;

   assign w_op_div    = op_is_div(int'(bus.op));
   assign w_op_signed = op_is_signed(int'(bus.op));
   assign w_sx        = w_op_signed & bus.x[WIDTH-1];
   assign w_sy        = w_op_signed & bus.y[WIDTH-1];
   assign w_x_mag     = w_sx ? -bus.x : bus.x;
   assign w_y_mag     = w_sy ? -bus.y : bus.y;
   assign w_accept    = (r_state == S_IDLE) & bus.in_valid & ~bus.flush & op_legal(int'(bus.op));

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_acc  (r_acc),
      .i_opnd (r_opnd),
      .i_mode (r_mode),
      .o_acc  (w_step_acc),
      .o_qbit (w_step_qbit)
   );

   // Sign fix-up: magnitudes were iterated, signs are restored on the final BUSY cycle.
   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept)             w_state_nxt = S_BUSY;
         S_BUSY:  if (r_cnt == '0)          w_state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready)        w_state_nxt = S_IDLE;
         default:                           w_state_nxt = S_IDLE;
      endcase
      if (bus.flush) w_state_nxt = S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_opnd  <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_mode  <= M_MUL;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_div0  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mode  <= w_op_div ? M_DIV : M_MUL;
                  r_acc   <= {{WIDTH{1'b0}}, w_x_mag};
                  r_opnd  <= w_y_mag;
                  r_cnt   <= CNT_W'(WIDTH);
                  r_neg_q <= w_sx ^ w_sy;
                  r_neg_r <= w_sx;
                  r_div0  <= 1'b0;
`ifdef MDU_DIV0_EN
                  if (w_op_div && (bus.y == '0)) begin
                     r_acc   <= {bus.x, {WIDTH{1'b1}}};
                     r_cnt   <= '0;
                     r_neg_q <= 1'b0;
                     r_neg_r <= 1'b0;
                     r_div0  <= 1'b1;
                  end
`endif
               end
            end
            S_BUSY: begin
               if (r_cnt != '0) begin
                  r_acc <= {w_step_acc[2*WIDTH-1:1],
                            (r_mode == M_DIV) ? w_step_qbit : w_step_acc[0]};
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_mode == M_MUL) begin
                  r_lo <= w_prod[WIDTH-1:0];
                  r_hi <= w_prod[2*WIDTH-1:WIDTH];
               end else begin
                  r_lo <= w_quo;
                  r_hi <= w_rem;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.lo        = r_lo;
   assign bus.hi        = r_hi;
`ifdef MDU_DIV0_EN
   assign bus.div0      = r_div0 & (r_state == S_DONE);
`endif

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter (WIDTH=32): literal expectations per operation plus an arithmetic reference model.
module tb_muldiv_iter;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;

   muldiv_iter_if #(.WIDTH(W), .OP_W(4)) bus ();

   muldiv_iter #(.WIDTH(W), .OP_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } res_t;

   int   n_checks = 0;
   int   n_errors = 0;
   res_t exp_q[$];
   bit   inflight = 1'b0;
   bit   hs_prev  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit is_legal(input logic [3:0] o);
      return (o == 4'd3) || (o == 4'd4) || (o == 4'd13) || (o == 4'd14);
   endfunction

   // Reference arithmetic: 64-bit integer math, truncating division, remainder follows the dividend.
   function automatic res_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t        r;
      logic [63:0] p;
      longint      sa;
      longint      sb;
      longint      q;
      longint      m;
      r  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         4'd3: begin
            p = {32'h0, a} * {32'h0, b};
            r.lo = p[31:0];
            r.hi = p[63:32];
         end
         4'd13: begin
            p = 64'(sa * sb);
            r.lo = p[31:0];
            r.hi = p[63:32];
         end
         4'd4: begin
            if (b == 0) begin
               r.lo = '1;
               r.hi = a;
            end else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
         4'd14: begin
            if (b == 0) begin
               r.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
               r.hi = a;
            end else begin
               q = sa / sb;
               m = sa % sb;
               r.lo = q[31:0];
               r.hi = m[31:0];
            end
         end
         default: ;
      endcase
      return r;
   endfunction

   // Compare process: tracks accepted ops and checks the outputs on every meaningful cycle.
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         inflight = 1'b0;
         hs_prev  = 1'b0;
      end else begin
         if (hs_prev) begin
            check("idle_after_hs_out_valid", 64'(bus.out_valid), 64'd0);
            check("idle_after_hs_in_ready", 64'(bus.in_ready), 64'd1);
         end
         hs_prev = 1'b0;
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
            end else begin
               check("model_lo", 64'(bus.lo), 64'(exp_q[0].lo));
               check("model_hi", 64'(bus.hi), 64'(exp_q[0].hi));
               check("done_in_ready", 64'(bus.in_ready), 64'd0);
               check("done_busy", 64'(bus.busy), 64'd1);
               if (bus.out_ready && !bus.flush) begin
                  void'(exp_q.pop_front());
                  inflight = 1'b0;
                  hs_prev  = 1'b1;
               end
            end
         end else if (inflight) begin
            check("busy_in_ready", 64'(bus.in_ready), 64'd0);
            check("busy_flag", 64'(bus.busy), 64'd1);
         end
         if (bus.flush) begin
            exp_q.delete();
            inflight = 1'b0;
            hs_prev  = 1'b0;
         end else if (bus.in_valid && bus.in_ready && is_legal(bus.op)) begin
            exp_q.push_back(model(bus.op, bus.x, bus.y));
            inflight = 1'b1;
         end
      end
   end

   task automatic run_op(input string name, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] e_lo,
                         input logic [W-1:0] e_hi, input int hold);
      int n;
      bit got;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op       = o;
      bus.x        = a;
      bus.y        = b;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n   = 0;
      got = 1'b0;
      while (n < 100 && !got) begin
         @(posedge clk); #1;
         n++;
         got = bus.out_valid;
      end
      check($sformatf("%s_latency", name), 64'(n), 64'd33);
      if (got) begin
         check($sformatf("%s_lo", name), 64'(bus.lo), 64'(e_lo));
         check($sformatf("%s_hi", name), 64'(bus.hi), 64'(e_hi));
         for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check($sformatf("%s_hold_valid", name), 64'(bus.out_valid), 64'd1);
            check($sformatf("%s_hold_in_ready", name), 64'(bus.in_ready), 64'd0);
            check($sformatf("%s_hold_lo", name), 64'(bus.lo), 64'(e_lo));
            check($sformatf("%s_hold_hi", name), 64'(bus.hi), 64'(e_hi));
         end
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
         check($sformatf("%s_back_to_idle", name), 64'(bus.in_ready), 64'd1);
      end
   endtask

   initial begin
      logic [3:0] bad_ops [3];
      bad_ops = '{4'd0, 4'd5, 4'd15};
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = '0;
      bus.x         = '0;
      bus.y         = '0;
      bus.out_ready = 1'b0;
      rst           = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      #2 rst = 1'b1;

      run_op("divu_100_7",   4'd4,  32'd100,        32'd7,         32'd14,        32'd2,         5);
      run_op("div_m7_2",     4'd14, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
      run_op("div_7_m2",     4'd14, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         0);
      run_op("div_min_m1",   4'd14, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         0);
      run_op("mult_m3_5",    4'd13, 32'hFFFF_FFFD,  32'd5,         32'hFFFF_FFF1, 32'hFFFF_FFFF, 0);
      run_op("multu_max",    4'd3,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE, 0);
      run_op("multu_2p32",   4'd3,  32'h0001_0000,  32'h0001_0000, 32'd0,         32'd1,         0);
      run_op("mult_max_min", 4'd13, 32'h7FFF_FFFF,  32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 0);
      run_op("divu_max_1",   4'd4,  32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 32'd0,         0);
      run_op("divu_by0",     4'd4,  32'd12345,      32'd0,         32'hFFFF_FFFF, 32'd12345,     0);
      run_op("div_m20_by0",  4'd14, 32'hFFFF_FFEC,  32'd0,         32'd1,         32'hFFFF_FFEC, 0);

      // Illegal opcodes must be ignored while the unit is idle.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         bus.in_valid = 1'b1;
         bus.op       = bad_ops[k];
         bus.x        = 32'd9;
         bus.y        = 32'd3;
         @(posedge clk); #1;
         check($sformatf("illegal_op%0d_in_ready", bad_ops[k]), 64'(bus.in_ready), 64'd1);
         check($sformatf("illegal_op%0d_busy", bad_ops[k]), 64'(bus.busy), 64'd0);
      end
      bus.in_valid = 1'b0;

      // Flush ten cycles into a divide while a new op is offered in the same cycle.
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op       = 4'd14;
      bus.x        = 32'd1000;
      bus.y        = 32'd3;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.op       = 4'd3;
      bus.x        = 32'd3;
      bus.y        = 32'd4;
      @(posedge clk); #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      check("flush_in_ready", 64'(bus.in_ready), 64'd1);
      check("flush_busy", 64'(bus.busy), 64'd0);
      repeat (40) @(posedge clk);
      #1;
      check("flush_no_late_result", 64'(bus.out_valid), 64'd0);
      check("flush_new_op_not_taken", 64'(bus.in_ready), 64'd1);

      // Async reset in the middle of a multiply, with a nonzero prior result on hi/lo.
      run_op("divu_pre_rst", 4'd4, 32'd100, 32'd7, 32'd14, 32'd2, 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.op       = 4'd13;
      bus.x        = 32'hFFFF_FFFD;
      bus.y        = 32'd5;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
      check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("async_rst_busy", 64'(bus.busy), 64'd0);
      check("async_rst_lo", 64'(bus.lo), 64'd0);
      check("async_rst_hi", 64'(bus.hi), 64'd0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;

      run_op("div_after_rst", 4'd14, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 2);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
